burst_clk_gen: RTL and testbench

//  Next-generation transmit/receive timing source for the Doppler beam scanner, all on CLK64.

---
 rtl/dop_clk_pkg.sv | 15 +
 rtl/burst_clk_gen_if.sv | 31 +++
 rtl/prog_clk_div.sv | 27 ++
 rtl/burst_clk_gen.sv | 173 +++++++++++++++++
 tb/tb_burst_clk_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dop_clk_pkg.sv
// rtl/dop_clk_pkg.sv - shared state encoding and reset defaults for the burst clock generator
package dop_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POS   = 3'd1,
    ST_GAP_P = 3'd2,
    ST_NEG   = 3'd3,
    ST_GAP_N = 3'd4
  } burst_state_e;

  localparam int DEF_DIV  = 8;
  localparam int DEF_NCYC = 4;

endpackage

// File: rtl/burst_clk_gen_if.sv
// rtl/burst_clk_gen_if.sv - host config / front-end signal bundle of the burst clock generator
interface burst_clk_gen_if #(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 6,
  parameter int ADC_DIV_W = 4
);

  logic [DIV_W-1:0]     FREQ_DIV;
  logic [CNT_W-1:0]     N_CYC;
  logic [ADC_DIV_W-1:0] ADC_DIV;
  logic                 WR_Freq;
  logic                 BURST_EN;
  logic                 ADC_EN;
  logic                 CLK_4MHz;
  logic                 BURST_P;
  logic                 BURST_N;
  logic                 CLK_ADC;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output FREQ_DIV, N_CYC, ADC_DIV, WR_Freq, BURST_EN, ADC_EN,
    input  CLK_4MHz, BURST_P, BURST_N, CLK_ADC, BUSY, DONE
  );

  modport slave (
    input  FREQ_DIV, N_CYC, ADC_DIV, WR_Freq, BURST_EN, ADC_EN,
    output CLK_4MHz, BURST_P, BURST_N, CLK_ADC, BUSY, DONE
  );

endinterface

// File: rtl/prog_clk_div.sv
// rtl/prog_clk_div.sv - enabled toggle divider; output flips every div+1 cycles, held low when disabled
module prog_clk_div #(
  parameter int W = 4
) (
  input  logic         CLK64,
  input  logic         RES,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         clk_o
);

  logic [W-1:0] cnt;

  // Disabling clears both counter and output so a re-enable always starts a fresh low phase.
  always_ff @(posedge CLK64) begin
    if (RES || !en) begin
      cnt   <= '0;
      clk_o <= 1'b0;
    end else if (cnt == div) begin
      cnt   <= '0;
      clk_o <= ~clk_o;
    end else begin
      cnt   <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/burst_clk_gen.sv
// rtl/burst_clk_gen.sv - complementary pulser burst with dead time, gated ADC clock and reference clock
module burst_clk_gen #(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 6,
  parameter int ADC_DIV_W = 4,
  parameter int DEAD      = 1,
  parameter int REF_LOG2  = 4,
  parameter int DEF_DIV   = dop_clk_pkg::DEF_DIV,
  parameter int DEF_NCYC  = dop_clk_pkg::DEF_NCYC
) (
  input  logic           CLK64,
  input  logic           RES,
  burst_clk_gen_if.slave bus
);

  import dop_clk_pkg::*;

  logic [DIV_W-1:0]     div_r;
  logic [CNT_W-1:0]     n_cyc_r;
  logic [ADC_DIV_W-1:0] adc_div_r;
  logic                 wr_d;
  logic                 bst_d;
  logic                 pend;
  logic                 wr_rise;
  logic                 bst_rise;

  burst_state_e         state;
  burst_state_e         next_state;
  logic [DIV_W-1:0]     phase_cnt;
  logic [DIV_W-1:0]     phase_len;
  logic [DIV_W-1:0]     div_eff;
  logic [CNT_W-1:0]     per_cnt;
  logic                 phase_end;
  logic                 period_end;
  logic                 last_per;
  logic                 per_inc;
  logic                 done_nxt;
  logic                 p_nxt;
  logic                 n_nxt;
  logic                 busy_nxt;

  logic                 burst_p;
  logic                 burst_n;
  logic                 busy;
  logic                 done;
  logic [REF_LOG2-1:0]  ref_cnt;
  logic                 clk_adc;

  assign wr_rise  = bus.WR_Freq & ~wr_d;
  assign bst_rise = bus.BURST_EN & ~bst_d;

  // A zero divider would give an empty phase; run it as a single-cycle phase instead.
  assign div_eff    = (div_r == '0) ? DIV_W'(1) : div_r;
  assign phase_len  = (state == ST_POS || state == ST_NEG) ? div_eff : DIV_W'(DEAD);
  assign phase_end  = (phase_cnt == phase_len - DIV_W'(1));
  assign period_end = phase_end &&
                      ((state == ST_GAP_N) || (state == ST_NEG && DEAD == 0));
  assign last_per   = ((per_cnt + CNT_W'(1)) == n_cyc_r);

  // Config is only ever loaded while idle so a running burst keeps its settings.
  always_ff @(posedge CLK64) begin
    if (RES) begin
      wr_d      <= 1'b0;
      bst_d     <= 1'b0;
      pend      <= 1'b0;
      div_r     <= DIV_W'(DEF_DIV);
      n_cyc_r   <= CNT_W'(DEF_NCYC);
      adc_div_r <= '0;
    end else begin
      wr_d  <= bus.WR_Freq;
      bst_d <= bus.BURST_EN;
      if (state == ST_IDLE) begin
        if (wr_rise || pend) begin
          div_r     <= bus.FREQ_DIV;
          n_cyc_r   <= bus.N_CYC;
          adc_div_r <= bus.ADC_DIV;
        end
        pend <= 1'b0;
      end else if (wr_rise) begin
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK64) begin
    if (RES) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      per_cnt   <= '0;
      burst_p   <= 1'b0;
      burst_n   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      phase_cnt <= (state == ST_IDLE || phase_end) ? '0 : phase_cnt + DIV_W'(1);
      if (state == ST_IDLE)
        per_cnt <= '0;
      else if (per_inc)
        per_cnt <= per_cnt + CNT_W'(1);
      burst_p   <= p_nxt;
      burst_n   <= n_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    next_state = state;
    done_nxt   = 1'b0;
    per_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bst_rise) begin
          if (n_cyc_r != '0)
            next_state = ST_POS;
          else
            done_nxt = 1'b1;
        end
      end
      ST_POS: begin
        if (phase_end)
          next_state = (DEAD != 0) ? ST_GAP_P : ST_NEG;
      end
      ST_GAP_P: begin
        if (phase_end)
          next_state = ST_NEG;
      end
      ST_NEG, ST_GAP_N: begin
        if (period_end) begin
          per_inc    = 1'b1;
          done_nxt   = last_per;
          next_state = last_per ? ST_IDLE : ST_POS;
        end else if (phase_end) begin
          next_state = ST_GAP_N;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with it.
  always_comb begin
    p_nxt    = (next_state == ST_POS);
    n_nxt    = (next_state == ST_NEG);
    busy_nxt = (next_state != ST_IDLE);
  end

  always_ff @(posedge CLK64) begin
    if (RES)
      ref_cnt <= '0;
    else
      ref_cnt <= ref_cnt + REF_LOG2'(1);
  end

  prog_clk_div #(
    .W (ADC_DIV_W)
  ) u_adc_div (
    .CLK64 (CLK64),
    .RES   (RES),
    .en    (bus.ADC_EN),
    .div   (adc_div_r),
    .clk_o (clk_adc)
  );

  assign bus.BURST_P  = burst_p;
  assign bus.BURST_N  = burst_n;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.CLK_4MHz = ref_cnt[REF_LOG2-1];
  assign bus.CLK_ADC  = clk_adc;

endmodule

// File: tb/tb_burst_clk_gen.sv
// tb/tb_burst_clk_gen.sv - self-checking bench for burst_clk_gen against a cycle-level reference model
module tb_burst_clk_gen;

  localparam int DEAD = 1;

  logic clk;
  logic res;

  burst_clk_gen_if bus ();

  burst_clk_gen dut (
    .CLK64 (clk),
    .RES   (res),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pn_viol  = 0;

  // reference model state
  int   m_div, m_ncyc, m_adiv;
  bit   m_pend, m_prev_wr, m_prev_en, m_active;
  int   m_k, m_d, m_total, m_per, m_e, m_rc, m_j;
  bit   mw_rise, me_rise, m_was, m_done, mp, mn, m_adc, m_ref;
  logic [5:0] exp_o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Burst: k counts cycles since start, position in the period gives P / gap / N / gap.
  always @(posedge clk) begin
    if (res) begin
      m_div = 8; m_ncyc = 4; m_adiv = 0; m_pend = 0;
      m_prev_wr = 0; m_prev_en = 0; m_active = 0;
      m_k = 0; m_d = 1; m_total = 0; m_per = 2; m_e = 0; m_rc = 0;
      exp_o = '0;
    end else begin
      mw_rise = bus.WR_Freq && !m_prev_wr;
      me_rise = bus.BURST_EN && !m_prev_en;
      m_prev_wr = bus.WR_Freq;
      m_prev_en = bus.BURST_EN;
      m_was  = m_active;
      m_done = 0;
      if (m_was) begin
        m_k++;
        if (m_k == m_total) begin
          m_active = 0;
          m_done = 1;
        end
      end else if (me_rise) begin
        if (m_ncyc != 0) begin
          m_active = 1;
          m_k = 0;
          m_d = (m_div == 0) ? 1 : m_div;
          m_per = 2 * (m_d + DEAD);
          m_total = m_ncyc * m_per;
        end else begin
          m_done = 1;
        end
      end
      if (!bus.ADC_EN) m_e = 0;
      else m_e++;
      m_adc = bus.ADC_EN && (((m_e / (m_adiv + 1)) % 2) == 1);
      if (!m_was) begin
        if (mw_rise || m_pend) begin
          m_div = int'(bus.FREQ_DIV); m_ncyc = int'(bus.N_CYC); m_adiv = int'(bus.ADC_DIV);
        end
        m_pend = 0;
      end else if (mw_rise) begin
        m_pend = 1;
      end
      m_rc  = (m_rc + 1) % 16;
      m_ref = (m_rc >= 8);
      m_j = m_k % m_per;
      mp = m_active && (m_j < m_d);
      mn = m_active && (m_j >= m_d + DEAD) && (m_j < 2 * m_d + DEAD);
      exp_o = {mp, mn, m_active, m_done, m_adc, m_ref};
    end
  end

  always @(negedge clk)
    if (bus.BURST_P === 1'b1 && bus.BURST_N === 1'b1) pn_viol++;

  task automatic tick();
    @(negedge clk);
    check_eq("outs", {bus.BURST_P, bus.BURST_N, bus.BUSY, bus.DONE, bus.CLK_ADC, bus.CLK_4MHz}, exp_o);
  endtask

  task automatic trig();
    bus.BURST_EN = 1'b1;
    tick();
    bus.BURST_EN = 1'b0;
  endtask

  task automatic wr_cfg(input int d, input int n, input int a);
    bus.FREQ_DIV = 8'(d);
    bus.N_CYC    = 6'(n);
    bus.ADC_DIV  = 4'(a);
    bus.WR_Freq  = 1'b1;
    tick();
    bus.WR_Freq  = 1'b0;
    tick();
  endtask

  task automatic observe(input int w, input int wr_at, output int blen, output int dn,
                         output int fdone, output int pc, output int nc);
    blen = 0; dn = 0; fdone = -1; pc = 0; nc = 0;
    for (int i = 0; i < w; i++) begin
      if (bus.BUSY) blen++;
      if (bus.DONE) begin
        dn++;
        if (fdone < 0) fdone = i;
      end
      if (bus.BURST_P) pc++;
      if (bus.BURST_N) nc++;
      bus.WR_Freq = (i == wr_at);
      tick();
    end
    bus.WR_Freq = 1'b0;
  endtask

  int bl, dn, fd, pc, nc;
  int r1, r2, q1, q2;
  logic pa, pr;

  initial begin
    res = 1'b1;
    bus.FREQ_DIV = '0; bus.N_CYC = '0; bus.ADC_DIV = '0;
    bus.WR_Freq = 1'b0; bus.BURST_EN = 1'b0; bus.ADC_EN = 1'b0;
    repeat (3) tick();
    check_eq("reset_outs", {bus.BURST_P, bus.BURST_N, bus.BUSY, bus.DONE, bus.CLK_ADC, bus.CLK_4MHz}, 0);
    res = 1'b0;
    tick();

    // defaults: 4 periods of 8/1/8/1
    trig();
    observe(100, -1, bl, dn, fd, pc, nc);
    check_eq("t1_busy_len", bl, 72);
    check_eq("t1_done_cnt", dn, 1);
    check_eq("t1_done_at", fd, 72);
    check_eq("t1_p_cycles", pc, 32);
    check_eq("t1_n_cycles", nc, 32);

    wr_cfg(3, 2, 0);
    trig();
    check_eq("t2_p_latency", bus.BURST_P, 1);
    observe(30, -1, bl, dn, fd, pc, nc);
    check_eq("t2_busy_len", bl, 16);
    check_eq("t2_done_at", fd, 16);

    // reconfigure mid-burst: takes effect only on the following burst
    bus.FREQ_DIV = 8'd2;
    trig();
    observe(30, 4, bl, dn, fd, pc, nc);
    check_eq("t3_old_div_len", bl, 16);
    check_eq("t3_old_done_at", fd, 16);
    repeat (3) tick();
    trig();
    observe(30, -1, bl, dn, fd, pc, nc);
    check_eq("t3_new_div_len", bl, 12);
    check_eq("t3_new_p_cycles", pc, 4);

    wr_cfg(3, 0, 0);
    trig();
    observe(8, -1, bl, dn, fd, pc, nc);
    check_eq("t4_done_cnt", dn, 1);
    check_eq("t4_done_at", fd, 0);
    check_eq("t4_busy", bl, 0);
    check_eq("t4_drive", pc + nc, 0);

    wr_cfg(8, 4, 0);
    trig();
    repeat (3) tick();
    res = 1'b1;
    tick();
    check_eq("t5_abort", {bus.BURST_P, bus.BURST_N, bus.BUSY}, 0);
    res = 1'b0;
    observe(10, -1, bl, dn, fd, pc, nc);
    check_eq("t5_no_done", dn, 0);
    trig();
    observe(100, -1, bl, dn, fd, pc, nc);
    check_eq("t5_rerun_len", bl, 72);
    check_eq("t5_rerun_done", dn, 1);

    wr_cfg(8, 4, 1);
    bus.ADC_EN = 1'b1;
    r1 = -1; r2 = -1; q1 = -1; q2 = -1;
    pa = bus.CLK_ADC; pr = bus.CLK_4MHz;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.CLK_ADC && !pa) begin
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
      if (bus.CLK_4MHz && !pr) begin
        if (q1 < 0) q1 = i; else if (q2 < 0) q2 = i;
      end
      pa = bus.CLK_ADC; pr = bus.CLK_4MHz;
    end
    check_eq("t6_adc_first_rise", r1, 2);
    check_eq("t6_adc_period", r2 - r1, 4);
    check_eq("t6_ref_period", q2 - q1, 16);
    for (int i = 0; i < 10 && !bus.CLK_ADC; i++) tick();
    check_eq("t6_adc_high_seen", bus.CLK_ADC, 1);
    bus.ADC_EN = 1'b0;
    tick();
    check_eq("t6_adc_drop", bus.CLK_ADC, 0);

    // randomized traffic; triggers avoid coinciding with config loads
    begin
      int adiv;
      adiv = $urandom_range(0, 3);
      wr_cfg($urandom_range(0, 5), $urandom_range(0, 4), adiv);
      for (int c = 0; c < 4000; c++) begin
        if (bus.BURST_EN) begin
          if ($urandom_range(0, 1) == 1) bus.BURST_EN = 1'b0;
        end else if (!m_active && !m_pend && !bus.WR_Freq && $urandom_range(0, 7) == 0) begin
          bus.BURST_EN = 1'b1;
        end else if (m_active && $urandom_range(0, 15) == 0) begin
          bus.BURST_EN = 1'b1;
        end
        if (bus.WR_Freq) begin
          bus.WR_Freq = 1'b0;
        end else if (!bus.BURST_EN && $urandom_range(0, 9) == 0) begin
          bus.FREQ_DIV = 8'($urandom_range(0, 5));
          bus.N_CYC    = 6'($urandom_range(0, 4));
          bus.WR_Freq  = 1'b1;
        end
        if ($urandom_range(0, 39) == 0) bus.ADC_EN = ~bus.ADC_EN;
        tick();
      end
    end

    check_eq("pn_exclusive", pn_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
